pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/pipe_shifter.sv | 139 +++++++++++++
 tb/tb_pipe_shifter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_shifter.sv
// Pipelined shifter/rotator: one registered stage per shift-amount bit, with a
// back-pressured valid/ready chain so a full pipe stalls from the output end.
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never depends on ready, and a stalled stage holds every field.
  logic [SW-1:0]    valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [SW];
  logic [WIDTH-1:0] data_d  [SW];
  logic [SW-1:0]    shamt_q [SW];
  logic [SW-1:0]    shamt_d [SW];
  logic [2:0]       mode_q  [SW];
  logic [2:0]       mode_d  [SW];
  logic [TAG_W-1:0] tag_q   [SW];
  logic [TAG_W-1:0] tag_d   [SW];

  logic [SW-1:0]    rdy;
  logic [SW-1:0]    src_valid;
  logic [WIDTH-1:0] src_data  [SW];
  logic [SW-1:0]    src_shamt [SW];
  logic [2:0]       src_mode  [SW];
  logic [TAG_W-1:0] src_tag   [SW];

  function automatic logic [WIDTH-1:0] shift_stage(input logic [WIDTH-1:0] d,
                                                   input logic [2:0]       mode,
                                                   input int               amt);
    logic [WIDTH-1:0] r;
    r = d;
    case (mode)
      MODE_SLL: r = d << amt;
      MODE_SRL: r = d >> amt;
      MODE_SRA: r = $signed(d) >>> amt;
      MODE_ROL: r = (d << amt) | (d >> (WIDTH - amt));
      MODE_ROR: r = (d >> amt) | (d << (WIDTH - amt));
      default:  r = d;
    endcase
    return r;
  endfunction

  // rdy[k] = !valid[k] || rdy[k+1], unrolled from the output end.
  always_comb begin : ready_chain
    logic ready_acc;
    rdy       = '0;
    ready_acc = out_ready;
    for (int k = SW - 1; k >= 0; k--) begin
      ready_acc = !valid_q[k] || ready_acc;
      rdy[k]    = ready_acc;
    end
  end

  assign in_ready = rdy[0] && !rst && !flush;

  always_comb begin
    src_valid    = '0;
    src_valid[0] = in_valid && in_ready;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_mode[0]  = in_mode;
    src_tag[0]   = in_tag;
    for (int k = 1; k < SW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_mode[k]  = mode_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end
  end

  // Stage k applies a shift of 2^k when bit k of its operation's amount is set.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    tag_d   = tag_q;
    for (int k = 0; k < SW; k++) begin
      if (rdy[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          data_d[k]  = src_shamt[k][k] ? shift_stage(src_data[k], src_mode[k], 1 << k)
                                       : src_data[k];
          shamt_d[k] = src_shamt[k];
          mode_d[k]  = src_mode[k];
          tag_d[k]   = src_tag[k];
        end
      end
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < SW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        mode_q[k]  <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < SW; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
        mode_q[k]  <= mode_d[k];
        tag_q[k]   <= tag_d[k];
      end
    end
  end

  assign out_valid = valid_q[SW-1];
  assign out_data  = data_q[SW-1];
  assign out_tag   = tag_q[SW-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter at WIDTH=8: fixed vectors, stall/flush/reset sequences
// and a randomized run scored against an arithmetic reference model.
module tb_pipe_shifter;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int SW    = 3;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [SW-1:0]    in_shamt;
  logic [2:0]       in_mode;
  logic [TAG_W-1:0] in_tag, out_tag;

  int errors = 0;
  int checks = 0;

  pipe_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                           input logic [2:0] m);
    int v, n, sv;
    v = int'(d);
    n = int'(s);
    case (m)
      3'd0: v = (v << n) & 255;
      3'd1: v = v >> n;
      3'd2: begin
        sv = d[7] ? v - 256 : v;
        v  = (sv >>> n) & 255;
      end
      3'd3: v = ((v << n) | (v >> (8 - n))) & 255;
      3'd4: v = ((v >> n) | (v << (8 - n))) & 255;
      default: v = int'(d);
    endcase
    return v[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [TAG_W+WIDTH-1:0] exp_q[$];
  logic [TAG_W+WIDTH-1:0] exp_e;
  logic                   prev_stall = 1'b0;
  logic [WIDTH-1:0]       held_d;
  logic [TAG_W-1:0]       held_t;
  int accepts = 0;
  int ov_cnt  = 0;
  int run     = 0;
  int run_max = 0;

  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data_tag", {20'd0, out_tag, out_data}, {20'd0, held_t, held_d});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("result", {20'd0, out_tag, out_data}, {20'd0, exp_e});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, ref_shift(in_data, in_shamt, in_mode)});
        accepts++;
      end
      prev_stall = out_valid && !out_ready;
      held_d     = out_data;
      held_t     = out_tag;
    end
    if (out_valid === 1'b1) begin
      ov_cnt++;
      run++;
      if (run > run_max) run_max = run;
    end else begin
      run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  typedef struct {
    logic [2:0] mode;
    logic [7:0] data;
    logic [2:0] shamt;
    logic [3:0] tag;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] m, input logic [7:0] d, input logic [2:0] s,
                        input logic [3:0] t);
    in_mode  = m;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
  endtask

  task automatic rand_op(input logic [3:0] t);
    set_op(3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)), t);
  endtask

  // Single operation through an idle pipe: checks latency, data and tag.
  task automatic apply_vec(input vec_t v);
    int lat;
    set_op(v.mode, v.data, v.shamt, v.tag);
    in_valid = 1'b1;
    @(negedge clk);
    check("vec_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("vec_latency", lat, 3);
    check("vec_data", {24'd0, out_data}, {24'd0, v.exp});
    check("vec_tag", {28'd0, out_tag}, {28'd0, v.tag});
    tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  ov0, acc0;
    logic hs;

    vecs[0] = '{3'b010, 8'h96, 3'd3, 4'h5, 8'hF2};
    vecs[1] = '{3'b011, 8'h96, 3'd3, 4'h1, 8'hB4};
    vecs[2] = '{3'b100, 8'h96, 3'd1, 4'h2, 8'h4B};
    vecs[3] = '{3'b000, 8'h01, 3'd7, 4'h3, 8'h80};
    vecs[4] = '{3'b001, 8'h80, 3'd7, 4'h4, 8'h01};
    vecs[5] = '{3'b111, 8'h96, 3'd5, 4'h6, 8'h96};
    vecs[6] = '{3'b001, 8'h96, 3'd2, 4'h7, 8'h25};
    vecs[7] = '{3'b000, 8'h96, 3'd4, 4'h8, 8'h60};
    vecs[8] = '{3'b011, 8'h96, 3'd0, 4'h9, 8'h96};
    vecs[9] = '{3'b101, 8'h3C, 3'd6, 4'hA, 8'h3C};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(3'd0, 8'd0, 3'd0, 4'd0);

    // reset
    @(negedge clk);
    check("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_tag", {28'd0, out_tag}, 32'd0);
    tick();

    // directed vectors
    for (int i = 0; i < 10; i++) apply_vec(vecs[i]);

    // back-to-back, out_ready held high
    run_max = 0;
    for (int i = 0; i < 8; i++) begin
      rand_op(4'(i));
      in_valid = 1'b1;
      @(negedge clk);
      check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    check("b2b_consecutive_valid", run_max, 8);
    check("b2b_drain", exp_q.size(), 0);

    // stall: out_ready low for 6 cycles with continuous in_valid
    out_ready = 1'b0;
    acc0 = accepts;
    rand_op(4'h1);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      if (hs) rand_op(4'(c + 2));
    end
    check("stall_accepts", accepts - acc0, 3);
    @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("stall_drain", exp_q.size(), 0);

    // flush with two operations in flight
    rand_op(4'hB); in_valid = 1'b1; tick();
    rand_op(4'hC); tick();
    rand_op(4'hD); flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    ov0 = ov_cnt;
    repeat (6) tick();
    check("flush_no_result", ov_cnt - ov0, 0);
    apply_vec(vecs[0]);

    // reset mid-stream
    for (int i = 0; i < 5; i++) begin
      set_op(3'b111, 8'hFF, 3'd0, 4'(i + 1));
      in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
    check("midrst_out_tag", {28'd0, out_tag}, 32'd0);
    check("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    tick();
    ov0 = ov_cnt;
    repeat (6) tick();
    check("midrst_no_result", ov_cnt - ov0, 0);

    // randomized traffic with back-pressure and occasional flush
    hs = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || hs) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_op(4'($urandom));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      hs = in_valid && in_ready;
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    check("random_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
